// File: rtl/ti_pkg.sv
// Shared TI stop-handshake definitions: wrapper FSM state encoding
// and the outstanding-counter width helper used on both sides.
package ti_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_DRAIN   = 2'd1,
        ST_STOPPED = 2'd2,
        ST_RESUME  = 2'd3
    } ti_state_t;

    // Bits needed to hold 0..max_out inclusive.
    function automatic int ti_cw(input int max_out);
        return $clog2(max_out + 1);
    endfunction

endpackage

// File: rtl/ti_outstanding_counter.sv
// Saturating up/down counter of in-flight transactions.
// Ports: clk, rst (sync, active-high), inc, dec, count[CW-1:0],
//        overflow/underflow (1-cycle pulses for dropped inputs).
module ti_outstanding_counter
    import ti_pkg::*;
#(
    parameter  int MAX_OUTSTANDING = 16,
    localparam int CW              = ti_cw(MAX_OUTSTANDING)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc,
    input  logic          dec,
    output logic [CW-1:0] count,
    output logic          overflow,
    output logic          underflow
);

    localparam logic [CW-1:0] MAX_C = CW'(MAX_OUTSTANDING);
    localparam logic [CW-1:0] ONE   = CW'(1);

    // Simultaneous inc and dec cancel, so neither limit can be hit.
    always_comb begin
        overflow  = inc & ~dec & (count == MAX_C);
        underflow = dec & ~inc & (count == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc && !dec && !overflow) begin
            count <= count + ONE;
        end else if (dec && !inc && !underflow) begin
            count <= count - ONE;
        end
    end

endmodule

// File: rtl/ti_wrapper_stop_ctrl.sv
// Wrapper-side TI stop handshake: blocks new issues, drains in-flight
// transactions, freezes the wrapped module and acks; resumes on release.
// Ports: clk, rst (sync, active-high), stop_req -> stop_ack,
//        req_issue/rsp_done (transaction tracking), hold_new, clk_en,
//        outstanding[CW-1:0], sticky err_timeout/overflow/underflow/protocol.
module ti_wrapper_stop_ctrl
    import ti_pkg::*;
#(
    parameter  int MAX_OUTSTANDING = 16,
    parameter  int DRAIN_TIMEOUT   = 1024,
    parameter  int RESUME_DELAY    = 2,
    localparam int CW              = ti_cw(MAX_OUTSTANDING)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stop_req,
    output logic          stop_ack,
    input  logic          req_issue,
    input  logic          rsp_done,
    output logic          hold_new,
    output logic          clk_en,
    output logic [CW-1:0] outstanding,
    output logic          err_timeout,
    output logic          err_overflow,
    output logic          err_underflow,
    output logic          err_protocol
);

    localparam int DTW = $clog2(DRAIN_TIMEOUT);
    localparam int RTW = (RESUME_DELAY > 1) ? $clog2(RESUME_DELAY) : 1;

    localparam logic [DTW-1:0] D_LAST = DTW'(DRAIN_TIMEOUT - 1);
    localparam logic [DTW-1:0] D_ONE  = DTW'(1);
    localparam logic [RTW-1:0] R_LAST = RTW'(RESUME_DELAY - 1);
    localparam logic [RTW-1:0] R_ONE  = RTW'(1);

    ti_state_t      state_q;
    ti_state_t      state_d;
    logic [DTW-1:0] drain_tmr;
    logic [RTW-1:0] res_tmr;
    logic           drain_expire;
    logic           ovf;
    logic           udf;

    ti_outstanding_counter #(
        .MAX_OUTSTANDING(MAX_OUTSTANDING)
    ) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .inc      (req_issue),
        .dec      (rsp_done),
        .count    (outstanding),
        .overflow (ovf),
        .underflow(udf)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Outputs decode from state_q only, so every transition shows up
    // on the pins one cycle after it is decided.
    always_comb begin
        state_d      = state_q;
        stop_ack     = 1'b0;
        hold_new     = 1'b1;
        clk_en       = 1'b1;
        drain_expire = 1'b0;
        unique case (state_q)
            ST_RUN: begin
                hold_new = 1'b0;
                if (stop_req) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!stop_req) begin
                    state_d = ST_RUN;
                end else if (outstanding == '0) begin
                    state_d = ST_STOPPED;
                end else if (drain_tmr == D_LAST) begin
                    state_d      = ST_STOPPED;
                    drain_expire = 1'b1;
                end
            end
            ST_STOPPED: begin
                stop_ack = 1'b1;
                clk_en   = 1'b0;
                if (!stop_req) begin
                    state_d = ST_RESUME;
                end
            end
            ST_RESUME: begin
                if (stop_req) begin
                    state_d = ST_DRAIN;
                end else if (res_tmr == R_LAST) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // Timers idle at zero outside their state, so entry needs no clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            drain_tmr <= '0;
            res_tmr   <= '0;
        end else begin
            drain_tmr <= (state_q == ST_DRAIN) ? drain_tmr + D_ONE : '0;
            res_tmr   <= (state_q == ST_RESUME) ? res_tmr + R_ONE : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_timeout   <= 1'b0;
            err_overflow  <= 1'b0;
            err_underflow <= 1'b0;
            err_protocol  <= 1'b0;
        end else begin
            err_timeout   <= err_timeout | drain_expire;
            err_overflow  <= err_overflow | ovf;
            err_underflow <= err_underflow | udf;
            err_protocol  <= err_protocol | (req_issue & hold_new);
        end
    end

endmodule

// File: tb/tb_ti_wrapper_stop_ctrl.sv
// Bench for ti_wrapper_stop_ctrl: directed stimulus feeding a
// cycle-tagged scoreboard drained by an independent monitor.
module tb_ti_wrapper_stop_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       rst;
    logic       stop_req, req_issue, rsp_done;
    logic       stop_ack, hold_new, clk_en;
    logic [4:0] outstanding;
    logic       err_timeout, err_overflow, err_underflow, err_protocol;

    logic       t_stop, t_issue, t_done;
    logic       t_ack, t_hold, t_en;
    logic [4:0] t_out;
    logic       t_eto, t_eov, t_eun, t_epr;

    logic       m_stop;
    logic [2:0] m_issue, m_done, m_ack, m_hold, m_en;
    logic [2:0] m_eto, m_eov, m_eun, m_epr;
    logic [4:0] m_out [3];

    ti_wrapper_stop_ctrl dut (
        .clk(clk), .rst(rst),
        .stop_req(stop_req), .stop_ack(stop_ack),
        .req_issue(req_issue), .rsp_done(rsp_done),
        .hold_new(hold_new), .clk_en(clk_en),
        .outstanding(outstanding),
        .err_timeout(err_timeout), .err_overflow(err_overflow),
        .err_underflow(err_underflow), .err_protocol(err_protocol)
    );

    ti_wrapper_stop_ctrl #(.DRAIN_TIMEOUT(8)) dut_t (
        .clk(clk), .rst(rst),
        .stop_req(t_stop), .stop_ack(t_ack),
        .req_issue(t_issue), .rsp_done(t_done),
        .hold_new(t_hold), .clk_en(t_en),
        .outstanding(t_out),
        .err_timeout(t_eto), .err_overflow(t_eov),
        .err_underflow(t_eun), .err_protocol(t_epr)
    );

    for (genvar g = 0; g < 3; g++) begin : g_w
        ti_wrapper_stop_ctrl u (
            .clk(clk), .rst(rst),
            .stop_req(m_stop), .stop_ack(m_ack[g]),
            .req_issue(m_issue[g]), .rsp_done(m_done[g]),
            .hold_new(m_hold[g]), .clk_en(m_en[g]),
            .outstanding(m_out[g]),
            .err_timeout(m_eto[g]), .err_overflow(m_eov[g]),
            .err_underflow(m_eun[g]), .err_protocol(m_epr[g])
        );
    end

    typedef struct {
        int cyc;
        int id;
        int v;
    } item_t;

    item_t sb[$];
    int checks = 0;
    int errors = 0;

    string names [14] = '{
        "stop_ack", "hold_new", "clk_en", "outstanding",
        "err_timeout", "err_overflow", "err_underflow", "err_protocol",
        "t_stop_ack", "t_err_timeout", "t_outstanding", "and_ack",
        "t_hold_new", "or_ack"
    };

    function automatic int get_sig(int id);
        case (id)
            0:  return int'(stop_ack);
            1:  return int'(hold_new);
            2:  return int'(clk_en);
            3:  return int'(outstanding);
            4:  return int'(err_timeout);
            5:  return int'(err_overflow);
            6:  return int'(err_underflow);
            7:  return int'(err_protocol);
            8:  return int'(t_ack);
            9:  return int'(t_eto);
            10: return int'(t_out);
            11: return int'(&m_ack);
            12: return int'(t_hold);
            13: return int'(|m_ack);
            default: return -1;
        endcase
    endfunction

    // Insert keeping the queue ordered by target cycle.
    task automatic want(int d, int id, int v);
        item_t it;
        int k;
        it.cyc = cyc + d;
        it.id  = id;
        it.v   = v;
        k = sb.size();
        while (k > 0 && sb[k-1].cyc > it.cyc) k--;
        sb.insert(k, it);
    endtask

    task automatic tick(int n);
        repeat (n) @(negedge clk);
    endtask

    always @(negedge clk) begin : monitor
        item_t it;
        int act;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            it  = sb.pop_front();
            act = get_sig(it.id);
            checks++;
            if (it.cyc != cyc || act != it.v) begin
                errors++;
                $display("FAIL %s cyc %0d: got %0d want %0d (seen cyc %0d)",
                         names[it.id], it.cyc, act, it.v, cyc);
            end
        end
    end

    initial begin
        rst = 1'b1;
        stop_req = 0; req_issue = 0; rsp_done = 0;
        t_stop = 0; t_issue = 0; t_done = 0;
        m_stop = 0; m_issue = '0; m_done = '0;
        tick(3);

        // Reset state
        want(1, 0, 0); want(1, 1, 0); want(1, 2, 1); want(1, 3, 0);
        want(1, 4, 0); want(1, 5, 0); want(1, 6, 0); want(1, 7, 0);
        rst = 1'b0;
        tick(2);

        // Idle stop and resume
        stop_req = 1;
        want(1, 1, 1); want(1, 0, 0); want(1, 2, 1);
        want(2, 0, 1); want(2, 2, 0); want(2, 1, 1);
        tick(8);
        stop_req = 0;
        want(1, 0, 0); want(1, 2, 1); want(1, 1, 1);
        want(2, 1, 1); want(3, 1, 0);
        tick(5);

        // Drain with three outstanding
        req_issue = 1;
        tick(3);
        req_issue = 0;
        stop_req  = 1;
        want(1, 1, 1); want(6, 3, 2); want(10, 3, 1); want(15, 3, 0);
        want(15, 0, 0); want(16, 0, 1); want(16, 4, 0);
        for (int i = 0; i < 16; i++) begin
            rsp_done = (i == 5 || i == 9 || i == 14);
            tick(1);
        end
        rsp_done = 0;
        tick(2);
        stop_req = 0;
        want(1, 0, 0);
        tick(5);

        // Counter: cancel, underflow, overflow
        req_issue = 1;
        tick(4);
        rsp_done = 1;
        want(1, 3, 4);
        tick(1);
        req_issue = 0;
        want(4, 3, 0); want(4, 6, 0);
        tick(4);
        want(1, 3, 0); want(1, 6, 1);
        tick(1);
        rsp_done  = 0;
        req_issue = 1;
        want(16, 3, 16); want(16, 5, 0);
        tick(16);
        want(1, 3, 16); want(1, 5, 1);
        tick(1);
        req_issue = 0;
        rsp_done  = 1;
        tick(16);
        rsp_done = 0;
        want(1, 3, 0);
        tick(2);

        // Drain abort
        req_issue = 1;
        tick(1);
        req_issue = 0;
        tick(1);
        stop_req = 1;
        want(1, 1, 1); want(2, 1, 1); want(3, 1, 0);
        want(1, 0, 0); want(2, 0, 0); want(3, 0, 0); want(4, 0, 0);
        tick(2);
        stop_req = 0;
        tick(3);

        // Protocol error while stopped, then reset from STOPPED
        stop_req = 1;
        rsp_done = 1;
        want(1, 3, 0); want(2, 0, 1); want(3, 0, 1); want(3, 2, 0);
        want(2, 7, 0); want(3, 7, 1); want(3, 3, 1); want(3, 5, 1);
        want(4, 0, 0); want(4, 2, 1); want(4, 3, 0); want(4, 5, 0);
        want(4, 6, 0); want(4, 7, 0);
        tick(1);
        rsp_done = 0;
        tick(1);
        req_issue = 1;
        tick(1);
        req_issue = 0;
        rst = 1;
        tick(1);
        rst = 0;
        stop_req = 0;
        tick(3);

        // Drain timeout (DRAIN_TIMEOUT=8)
        t_issue = 1;
        want(2, 10, 2);
        tick(2);
        t_issue = 0;
        t_stop  = 1;
        want(1, 12, 1); want(8, 8, 0); want(9, 8, 1);
        want(8, 9, 0); want(9, 9, 1);
        tick(12);
        t_stop = 0;
        tick(4);
        t_done = 1;
        tick(2);
        t_done = 0;
        tick(2);

        // Three wrappers, ANDed acks
        m_issue = 3'b110;
        tick(1);
        m_issue = 3'b100;
        tick(1);
        m_issue = 3'b000;
        m_stop  = 1;
        want(1, 11, 0); want(9, 11, 0); want(10, 11, 1);
        want(13, 11, 1); want(14, 11, 0); want(14, 13, 0);
        for (int i = 0; i < 13; i++) begin
            m_done = (i == 3) ? 3'b010 :
                     (i == 6 || i == 8) ? 3'b100 : 3'b000;
            tick(1);
        end
        m_done = '0;
        m_stop = 0;

        for (int i = 0; i < 200 && sb.size() > 0; i++) tick(1);
        if (sb.size() > 0) begin
            $display("FAIL scoreboard: got %0d pending want 0", sb.size());
            errors += sb.size();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
